hsv_core_issue_dispatch: RTL and testbench

Parametrised issue dispatcher that replaces fixed-count fork/skid-buffer stages with NUM_PORTS execution ports.
- Each port has its own FIFO of depth DEPTH.
- An integrated register scoreboard tracks pending destination writes and blocks RAW/WAW hazards.
- Sits between the decode/regfile-read stage and the exec-mem processing units.
- Supports flush with a registered acknowledge.

---
 rtl/hsv_core_issue_dispatch.sv | 113 +++++++++++
 tb/tb_hsv_core_issue_dispatch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_issue_dispatch.sv
// rtl/hsv_core_issue_dispatch.sv - issue dispatcher with per-port FIFOs and register scoreboard
module hsv_core_issue_dispatch #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 2,
    parameter int REG_W     = 5
) (
    input  logic                          clk_core,
    input  logic                          rst_core_n,
    input  logic                          flush_req,
    output logic                          flush_ack,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [NUM_PORTS-1:0]          in_port_sel,
    input  logic [REG_W-1:0]              in_rs1,
    input  logic [REG_W-1:0]              in_rs2,
    input  logic [REG_W-1:0]              in_rd,
    input  logic                          in_use_rs1,
    input  logic                          in_use_rs2,
    input  logic                          in_wr_rd,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    input  logic [(2**REG_W)-1:0]         commit_mask,
    output logic [(2**REG_W)-1:0]         pending_mask
);

    localparam int NREG  = 2**REG_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NREG-1:0]      eff;
    logic [NREG-1:0]      set_vec;
    logic                 hazard;
    logic [NUM_PORTS-1:0] sel_oh;
    logic                 sel_valid;
    logic                 sel_full;
    logic                 accept;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    // A commit landing this cycle already frees its register for the hazard check.
    assign eff = pending_mask & ~commit_mask;

    always_comb begin
        hazard = 1'b0;
        if (in_use_rs1 && eff[in_rs1] && (in_rs1 != '0)) hazard = 1'b1;
        if (in_use_rs2 && eff[in_rs2] && (in_rs2 != '0)) hazard = 1'b1;
        if (in_wr_rd   && eff[in_rd]  && (in_rd  != '0)) hazard = 1'b1;
    end

    // Isolate the lowest set bit so a multi-hot select targets the lowest port.
    assign sel_oh    = in_port_sel & (~in_port_sel + 1'b1);
    assign sel_valid = |in_port_sel;
    assign sel_full  = |(sel_oh & full);

    assign ready_o = ~flush_req & ~hazard & ~sel_full;
    assign accept  = valid_i & ready_o;
    assign push    = accept ? sel_oh : '0;
    assign pop     = flush_req ? '0 : (out_valid_o & out_ready_i);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;

        always_ff @(posedge clk_core or negedge rst_core_n) begin
            if (!rst_core_n) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (flush_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[p]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[p]) rd_ptr <= rd_ptr + 1'b1;
                case ({push[p], pop[p]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        assign full[p]                        = (cnt == CNT_W'(DEPTH));
        assign out_valid_o[p]                 = (cnt != '0);
        assign out_data[p*DATA_W +: DATA_W]   = mem[rd_ptr];
    end

    // x0 and discarded (zero-hot) instructions never mark a pending write.
    assign set_vec = (accept && in_wr_rd && (in_rd != '0) && sel_valid)
                   ? ({{(NREG-1){1'b0}}, 1'b1} << in_rd) : '0;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            pending_mask <= '0;
            flush_ack    <= 1'b0;
        end else begin
            flush_ack    <= flush_req;
            pending_mask <= flush_req ? '0 : (eff | set_vec);
        end
    end

endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// tb/tb_hsv_core_issue_dispatch.sv - directed bench with queue-based reference model
module tb_hsv_core_issue_dispatch;

    localparam int NP    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int RW    = 5;
    localparam int NREG  = 32;

    logic              clk_core;
    logic              rst_core_n;
    logic              flush_req;
    logic              flush_ack;
    logic              valid_i;
    logic              ready_o;
    logic [DW-1:0]     in_data;
    logic [NP-1:0]     in_port_sel;
    logic [RW-1:0]     in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2, in_wr_rd;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_valid_o;
    logic [NP-1:0]     out_ready_i;
    logic [NREG-1:0]   commit_mask;
    logic [NREG-1:0]   pending_mask;

    hsv_core_issue_dispatch #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .REG_W(RW)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .valid_i(valid_i), .ready_o(ready_o), .in_data(in_data),
        .in_port_sel(in_port_sel), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
        .out_data(out_data), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .commit_mask(commit_mask), .pending_mask(pending_mask)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0]   mq [NP][$];
    logic [NREG-1:0] m_pend = '0;
    logic            m_fack = 1'b0;
    logic            m_acc;
    int              m_s;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lowest(input logic [NP-1:0] s);
        int r = -1;
        for (int p = NP - 1; p >= 0; p--) if (s[p]) r = p;
        return r;
    endfunction

    function automatic logic m_ready();
        logic [NREG-1:0] e;
        int s;
        e = m_pend & ~commit_mask;
        s = lowest(in_port_sel);
        if (flush_req) return 1'b0;
        if (in_use_rs1 && e[in_rs1] && in_rs1 != 0) return 1'b0;
        if (in_use_rs2 && e[in_rs2] && in_rs2 != 0) return 1'b0;
        if (in_wr_rd && e[in_rd] && in_rd != 0) return 1'b0;
        if (s >= 0 && mq[s].size() == DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: advances on every clock edge, cleared by reset.
    initial forever begin
        @(posedge clk_core or negedge rst_core_n);
        if (!rst_core_n) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            m_pend = '0;
            m_fack = 1'b0;
        end else begin
            m_acc = valid_i && m_ready();
            m_s   = lowest(in_port_sel);
            if (flush_req) begin
                for (int p = 0; p < NP; p++) mq[p].delete();
                m_pend = '0;
            end else begin
                for (int p = 0; p < NP; p++)
                    if (mq[p].size() > 0 && out_ready_i[p]) void'(mq[p].pop_front());
                m_pend = m_pend & ~commit_mask;
                if (m_acc && m_s >= 0) begin
                    mq[m_s].push_back(in_data);
                    if (in_wr_rd && in_rd != 0) m_pend[in_rd] = 1'b1;
                end
            end
            m_fack = flush_req;
        end
    end

    // Per-cycle compare, mid-way through the low phase after inputs settle.
    initial forever begin
        @(negedge clk_core);
        #2;
        chk("ready", ready_o, m_ready());
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("valid%0d", p), out_valid_o[p], mq[p].size() > 0);
            if (mq[p].size() > 0)
                chk($sformatf("data%0d", p), out_data[p*DW +: DW], mq[p][0]);
        end
        chk("pending", pending_mask, m_pend);
        chk("flush_ack", flush_ack, m_fack);
    end

    task automatic idle();
        valid_i = 0; in_data = '0; in_port_sel = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_wr_rd = 0;
        commit_mask = '0; flush_req = 0;
    endtask

    task automatic issue(input logic [NP-1:0] sel, input logic [RW-1:0] rs1, input logic u1,
                         input logic [RW-1:0] rd, input logic wr, input logic [DW-1:0] d);
        idle();
        valid_i = 1; in_port_sel = sel; in_rs1 = rs1; in_use_rs1 = u1;
        in_rd = rd; in_wr_rd = wr; in_data = d;
    endtask

    initial begin
        rst_core_n = 1; idle(); out_ready_i = '0;
        #1 rst_core_n = 0;
        #2;
        chk("rst_valid", out_valid_o, 4'b0000);
        chk("rst_data", out_data, '0);
        chk("rst_pend", pending_mask, '0);
        chk("rst_fack", flush_ack, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        @(negedge clk_core); rst_core_n = 1;

        // single instruction to port 1
        @(negedge clk_core); issue(4'b0010, 0, 0, 5, 1, 64'hA1A1_0000_0000_0001);
        #3 chk("t1_ready", ready_o, 1'b1);
        @(negedge clk_core); idle();
        #3 chk("t1_valid", out_valid_o, 4'b0010);
        chk("t1_data", out_data[127:64], 64'hA1A1_0000_0000_0001);
        chk("t1_pend", pending_mask, 32'h0000_0020);
        out_ready_i = 4'b0010;
        @(negedge clk_core); out_ready_i = '0; commit_mask = 32'h20;
        #3 chk("t1_drain", out_valid_o, 4'b0000);

        // RAW hazard released by a same-cycle commit
        @(negedge clk_core); issue(4'b0001, 0, 0, 7, 1, 64'hB0B0_0000_0000_0007);
        @(negedge clk_core); issue(4'b0010, 7, 1, 8, 1, 64'hC0C0_0000_0000_0008);
        #3 chk("t2_blocked", ready_o, 1'b0);
        commit_mask = 32'h80;
        #1 chk("t2_unblock", ready_o, 1'b1);
        @(negedge clk_core); idle();
        #3 chk("t2_pend", pending_mask, 32'h0000_0100);
        chk("t2_valid", out_valid_o, 4'b0011);
        out_ready_i = 4'b0011;
        @(negedge clk_core); out_ready_i = '0; commit_mask = 32'h100;
        @(negedge clk_core); idle();

        // full port blocks only itself; no pass-through while full
        @(negedge clk_core); issue(4'b0100, 0, 0, 0, 0, 64'hD0);
        @(negedge clk_core); issue(4'b0100, 0, 0, 0, 0, 64'hD1);
        @(negedge clk_core); issue(4'b0100, 0, 0, 0, 0, 64'hD2);
        #3 chk("t3_full", ready_o, 1'b0);
        @(negedge clk_core); issue(4'b1000, 0, 0, 0, 0, 64'hD3);
        #3 chk("t3_other", ready_o, 1'b1);
        @(negedge clk_core); issue(4'b0100, 0, 0, 0, 0, 64'hD2); out_ready_i = 4'b0100;
        #3 chk("t3_nopass", ready_o, 1'b0);
        @(negedge clk_core); out_ready_i = '0;
        #3 chk("t3_after_pop", ready_o, 1'b1);
        @(negedge clk_core); idle();
        #3 chk("t3_valid", out_valid_o, 4'b1100);
        chk("t3_head", out_data[191:128], 64'hD1);
        out_ready_i = 4'b1111;
        repeat (2) @(negedge clk_core);
        out_ready_i = '0;
        #3 chk("t3_drained", out_valid_o, 4'b0000);

        // WAW with set-versus-commit collision on r9
        @(negedge clk_core); issue(4'b0001, 0, 0, 9, 1, 64'hE0);
        @(negedge clk_core); issue(4'b0010, 0, 0, 9, 1, 64'hE1);
        #3 chk("t4_waw", ready_o, 1'b0);
        commit_mask = 32'h200;
        #1 chk("t4_unblock", ready_o, 1'b1);
        @(negedge clk_core); idle();
        #3 chk("t4_pend", pending_mask, 32'h0000_0200);
        out_ready_i = 4'b0011;
        @(negedge clk_core); out_ready_i = '0; commit_mask = 32'h200;
        @(negedge clk_core); idle();
        #3 chk("t4_clean", pending_mask, '0);

        // x0 destination, zero-hot and multi-hot selects
        @(negedge clk_core); issue(4'b0001, 0, 1, 0, 1, 64'hF0);
        #3 chk("t5_x0_ready", ready_o, 1'b1);
        @(negedge clk_core); issue(4'b0000, 0, 0, 3, 1, 64'hF1);
        #3 chk("t5_zh_ready", ready_o, 1'b1);
        @(negedge clk_core); issue(4'b0110, 0, 0, 0, 0, 64'hF2);
        #3 chk("t5_pend", pending_mask, '0);
        chk("t5_valid", out_valid_o, 4'b0001);
        @(negedge clk_core); idle();
        #3 chk("t5_multihot", out_valid_o, 4'b0011);
        chk("t5_mh_data", out_data[127:64], 64'hF2);
        out_ready_i = 4'b0011;
        @(negedge clk_core); out_ready_i = '0;

        // flush with partially filled FIFOs and pending bits
        @(negedge clk_core); issue(4'b0001, 0, 0, 4, 1, 64'h40);
        @(negedge clk_core); issue(4'b0010, 0, 0, 6, 1, 64'h60);
        @(negedge clk_core); issue(4'b0100, 0, 0, 11, 1, 64'hB0);
        flush_req = 1; commit_mask = 32'h10;
        #3 chk("t6_ready", ready_o, 1'b0);
        @(negedge clk_core); idle();
        #3 chk("t6_valid", out_valid_o, 4'b0000);
        chk("t6_pend", pending_mask, '0);
        chk("t6_ack", flush_ack, 1'b1);
        @(negedge clk_core);
        #3 chk("t6_ack_drop", flush_ack, 1'b0);

        // asynchronous reset with state in flight
        @(negedge clk_core); issue(4'b0100, 0, 0, 10, 1, 64'h1234);
        @(negedge clk_core); idle();
        #1 rst_core_n = 0;
        #1 chk("t7_valid", out_valid_o, 4'b0000);
        chk("t7_pend", pending_mask, '0);
        chk("t7_data", out_data, '0);
        @(negedge clk_core); rst_core_n = 1;
        repeat (2) @(negedge clk_core);

        #3 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
